// File: rtl/score_keeper.sv
// Pong match-state controller: scores, game-over/winner, ball freeze and serve.
// Optional new_game debounce is enabled by defining SCORE_DEBOUNCE_EN.
module score_keeper #(
    parameter int unsigned WIN_SCORE     = 9,
    parameter int unsigned HOLD_CYCLES   = 1024,
    parameter int unsigned DEBOUNCE_BITS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       goal_p1,
    input  logic       goal_p2,
    input  logic       new_game,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       game_over,
    output logic       winner,
    output logic       freeze,
    output logic       serve,
    output logic       serve_dir
);

    localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(HOLD_CYCLES - 1);
    localparam logic [3:0] WinScore = 4'(WIN_SCORE);

    localparam logic [1:0] StHold = 2'd0;
    localparam logic [1:0] StPlay = 2'd1;
    localparam logic [1:0] StOver = 2'd2;

    if (WIN_SCORE < 1 || WIN_SCORE > 15 || HOLD_CYCLES < 1 || DEBOUNCE_BITS < 1) begin : g_cfg_bad
        $error("score_keeper: illegal parameter value");
    end

    logic       goal_p1_q, goal_p1_prev_q, goal_p2_q, goal_p2_prev_q;
    logic       ng_meta_q, ng_sync_q, ng_prev_q, ng_edge_q;
    logic       ng_level;
    logic       g1_edge, g2_edge;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      score_p1_q, score_p1_d, score_p2_q, score_p2_d;
    logic [3:0]      score_p1_inc, score_p2_inc;
    logic            game_over_q, game_over_d;
    logic            winner_q, winner_d;
    logic            freeze_q, freeze_d;
    logic            serve_q, serve_d;
    logic            serve_dir_q, serve_dir_d;

`ifdef SCORE_DEBOUNCE_EN
    logic [DEBOUNCE_BITS-1:0] db_cnt_q, db_cnt_d;
    logic                     db_lvl_q, db_lvl_d;

    // Level flips only after 2^DEBOUNCE_BITS consecutive cycles of disagreement.
    always_comb begin
        db_cnt_d = '0;
        db_lvl_d = db_lvl_q;
        if (ng_sync_q != db_lvl_q) begin
            if (db_cnt_q == '1) begin
                db_lvl_d = ng_sync_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_cnt_q <= '0;
            db_lvl_q <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            db_lvl_q <= db_lvl_d;
        end
    end

    assign ng_level = db_lvl_q;
`else
    assign ng_level = ng_sync_q;
`endif

    assign g1_edge = goal_p1_q & ~goal_p1_prev_q;
    assign g2_edge = goal_p2_q & ~goal_p2_prev_q;
    assign score_p1_inc = score_p1_q + 4'd1;
    assign score_p2_inc = score_p2_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        score_p1_d  = score_p1_q;
        score_p2_d  = score_p2_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        freeze_d    = freeze_q;
        serve_d     = 1'b0;
        serve_dir_d = serve_dir_q;
        if (ng_edge_q) begin
            score_p1_d  = 4'd0;
            score_p2_d  = 4'd0;
            game_over_d = 1'b0;
            state_d     = StHold;
            cnt_d       = CntLoad;
            freeze_d    = 1'b1;
        end else begin
            unique case (state_q)
                StHold: begin
                    freeze_d = 1'b1;
                    if (cnt_q == '0) begin
                        serve_d  = 1'b1;
                        freeze_d = 1'b0;
                        state_d  = StPlay;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StPlay: begin
                    if (g1_edge || g2_edge) begin
                        state_d  = StHold;
                        cnt_d    = CntLoad;
                        freeze_d = 1'b1;
                        if (g1_edge && !g2_edge) begin
                            score_p1_d  = score_p1_inc;
                            serve_dir_d = 1'b1;
                            if (score_p1_inc == WinScore) begin
                                state_d     = StOver;
                                winner_d    = 1'b0;
                                game_over_d = 1'b1;
                            end
                        end else if (g2_edge && !g1_edge) begin
                            score_p2_d  = score_p2_inc;
                            serve_dir_d = 1'b0;
                            if (score_p2_inc == WinScore) begin
                                state_d     = StOver;
                                winner_d    = 1'b1;
                                game_over_d = 1'b1;
                            end
                        end
                    end
                end
                StOver: begin
                    freeze_d    = 1'b1;
                    game_over_d = 1'b1;
                end
                default: begin
                    state_d  = StHold;
                    cnt_d    = CntLoad;
                    freeze_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            goal_p1_q      <= 1'b0;
            goal_p1_prev_q <= 1'b0;
            goal_p2_q      <= 1'b0;
            goal_p2_prev_q <= 1'b0;
            ng_meta_q      <= 1'b0;
            ng_sync_q      <= 1'b0;
            ng_prev_q      <= 1'b0;
            ng_edge_q      <= 1'b0;
            state_q        <= StHold;
            cnt_q          <= CntLoad;
            score_p1_q     <= 4'd0;
            score_p2_q     <= 4'd0;
            game_over_q    <= 1'b0;
            winner_q       <= 1'b0;
            freeze_q       <= 1'b1;
            serve_q        <= 1'b0;
            serve_dir_q    <= 1'b0;
        end else begin
            goal_p1_q      <= goal_p1;
            goal_p1_prev_q <= goal_p1_q;
            goal_p2_q      <= goal_p2;
            goal_p2_prev_q <= goal_p2_q;
            ng_meta_q      <= new_game;
            ng_sync_q      <= ng_meta_q;
            ng_prev_q      <= ng_level;
            ng_edge_q      <= ng_level & ~ng_prev_q;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            score_p1_q     <= score_p1_d;
            score_p2_q     <= score_p2_d;
            game_over_q    <= game_over_d;
            winner_q       <= winner_d;
            freeze_q       <= freeze_d;
            serve_q        <= serve_d;
            serve_dir_q    <= serve_dir_d;
        end
    end

    assign score_p1  = score_p1_q;
    assign score_p2  = score_p2_q;
    assign game_over = game_over_q;
    assign winner    = winner_q;
    assign freeze    = freeze_q;
    assign serve     = serve_q;
    assign serve_dir = serve_dir_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper with HOLD_CYCLES=4, WIN_SCORE=9.
module tb_score_keeper;

    localparam int unsigned Hold = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       goal_p1 = 1'b0;
    logic       goal_p2 = 1'b0;
    logic       new_game = 1'b0;
    logic [3:0] score_p1, score_p2;
    logic       game_over, winner, freeze, serve, serve_dir;

    int total = 0;
    int bad = 0;

    score_keeper #(
        .WIN_SCORE    (9),
        .HOLD_CYCLES  (Hold),
        .DEBOUNCE_BITS(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .goal_p1  (goal_p1),
        .goal_p2  (goal_p2),
        .new_game (new_game),
        .score_p1 (score_p1),
        .score_p2 (score_p2),
        .game_over(game_over),
        .winner   (winner),
        .freeze   (freeze),
        .serve    (serve),
        .serve_dir(serve_dir)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at the falling edge right after HOLD was entered.
    task automatic serve_after(input string tag, input int n);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i < n) begin
                check({tag, "_serve_low"}, 8'(serve), 8'd0);
                check({tag, "_freeze_high"}, 8'(freeze), 8'd1);
            end else begin
                check({tag, "_serve_pulse"}, 8'(serve), 8'd1);
                check({tag, "_freeze_drop"}, 8'(freeze), 8'd0);
            end
        end
        @(negedge clk);
        check({tag, "_serve_once"}, 8'(serve), 8'd0);
        check({tag, "_freeze_low"}, 8'(freeze), 8'd0);
    endtask

    initial begin
        int serves;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_p1", 8'(score_p1), 8'd0);
        check("rst_p2", 8'(score_p2), 8'd0);
        check("rst_freeze", 8'(freeze), 8'd1);
        check("rst_serve", 8'(serve), 8'd0);
        check("rst_over", 8'(game_over), 8'd0);
        check("rst_winner", 8'(winner), 8'd0);
        check("rst_dir", 8'(serve_dir), 8'd0);
        reset = 1'b0;
        serve_after("first", Hold);

        // Single goal held 10 cycles counts once
        goal_p1 = 1'b1;
        @(negedge clk);
        check("goal_latency", 8'(score_p1), 8'd0);
        @(negedge clk);
        check("goal_p1_score", 8'(score_p1), 8'd1);
        check("goal_dir", 8'(serve_dir), 8'd1);
        check("goal_freeze", 8'(freeze), 8'd1);
        serve_after("goal", Hold);
        repeat (3) @(negedge clk);
        goal_p1 = 1'b0;
        @(negedge clk);
        check("goal_once", 8'(score_p1), 8'd1);

        // Simultaneous goals: re-serve only
        goal_p1 = 1'b1;
        goal_p2 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("both_p1", 8'(score_p1), 8'd1);
        check("both_p2", 8'(score_p2), 8'd0);
        check("both_dir", 8'(serve_dir), 8'd1);
        check("both_freeze", 8'(freeze), 8'd1);
        goal_p1 = 1'b0;
        goal_p2 = 1'b0;
        serve_after("both", Hold);

        // Nine goals for player 2 end the game
        for (int i = 1; i <= 9; i++) begin
            goal_p2 = 1'b1;
            @(negedge clk);
            goal_p2 = 1'b0;
            @(negedge clk);
            check("p2_count", 8'(score_p2), 8'(i));
            if (i < 9) repeat (Hold) @(negedge clk);
        end
        check("over_flag", 8'(game_over), 8'd1);
        check("over_winner", 8'(winner), 8'd1);
        check("over_dir", 8'(serve_dir), 8'd0);
        repeat (6) @(negedge clk);
        check("over_freeze", 8'(freeze), 8'd1);
        check("over_no_serve", 8'(serve), 8'd0);
        goal_p1 = 1'b1;
        repeat (2) @(negedge clk);
        goal_p1 = 1'b0;
        @(negedge clk);
        check("over_p1_held", 8'(score_p1), 8'd1);
        check("over_still", 8'(game_over), 8'd1);

`ifdef SCORE_DEBOUNCE_EN
        // Short glitch is filtered
        new_game = 1'b1;
        repeat (5) @(negedge clk);
        new_game = 1'b0;
        repeat (15) @(negedge clk);
        check("glitch_over", 8'(game_over), 8'd1);
        check("glitch_p2", 8'(score_p2), 8'd9);

        // Long press restarts exactly once
        serves = 0;
        new_game = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (serve) serves++;
        end
        new_game = 1'b0;
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            if (serve) serves++;
        end
        check("press_over", 8'(game_over), 8'd0);
        check("press_p1", 8'(score_p1), 8'd0);
        check("press_p2", 8'(score_p2), 8'd0);
        check("press_serves", 8'(serves), 8'd1);
`else
        // Restart from OVER: cleared three edges after the press is first sampled
        serves = 0;
        new_game = 1'b1;
        repeat (2) @(negedge clk);
        new_game = 1'b0;
        @(negedge clk);
        check("ng_early_p2", 8'(score_p2), 8'd9);
        check("ng_early_over", 8'(game_over), 8'd1);
        @(negedge clk);
        check("ng_p1", 8'(score_p1), 8'd0);
        check("ng_p2", 8'(score_p2), 8'd0);
        check("ng_over", 8'(game_over), 8'd0);
        check("ng_freeze", 8'(freeze), 8'd1);
        check("ng_dir_kept", 8'(serve_dir), 8'd0);
        serve_after("ng", Hold);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (serve) serves++;
        end
        check("ng_no_retrigger", 8'(serves), 8'd0);
`endif

        // Asynchronous reset in the middle of HOLD
        goal_p1 = 1'b1;
        repeat (2) @(negedge clk);
        goal_p1 = 1'b0;
        check("pre_rst_p1", 8'(score_p1), 8'd1);
        check("pre_rst_dir", 8'(serve_dir), 8'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_p1", 8'(score_p1), 8'd0);
        check("arst_dir", 8'(serve_dir), 8'd0);
        check("arst_freeze", 8'(freeze), 8'd1);
        check("arst_serve", 8'(serve), 8'd0);
        repeat (2) @(negedge clk);
        check("arst_hold_serve", 8'(serve), 8'd0);
        reset = 1'b0;
        serve_after("arst", Hold);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule

// File: doc/score_keeper.md
# score_keeper

Match-state controller for pong. It takes goal events from the ball/collision logic, keeps both 4-bit scores, and decides game-over and the winner. It freezes the ball between points and issues the serve pulse that restarts play. Its score outputs feed the seven-segment score display directly; that display blinks once either score reaches 9, so WIN_SCORE defaults to 9.

## Interface
Parameters:
- WIN_SCORE, 9: score that ends the game; legal range 1..15.
- HOLD_CYCLES, 1024: freeze length in clk cycles after a goal, new game or reset; must be ≥ 1.
- DEBOUNCE_BITS, 16: debounce counter width; used only with SCORE_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- goal_p1  in  1  level from ball logic; high while the ball is past player 2's edge (player 1 scored).
- goal_p2  in  1  level; high while the ball is past player 1's edge (player 2 scored).
- new_game  in  1  raw push-button, asynchronous to clk.
- score_p1  out  4  player 1 score, 0..WIN_SCORE.
- score_p2  out  4  player 2 score, 0..WIN_SCORE.
- game_over  out  1  high while in OVER.
- winner  out  1  0 = player 1, 1 = player 2; valid only while game_over = 1.
- freeze  out  1  ball logic holds the ball stationary while high.
- serve  out  1  one-cycle pulse; ball logic relaunches the ball from centre.
- serve_dir  out  1  0 = serve toward player 1, 1 = toward player 2; sampled by ball logic on serve.

## Operation
- All outputs are registered.
- **Goal edge detection:** goal_p1 and goal_p2 are registered; a goal counts only on a 0→1 transition of the sampled level. A level held high counts once.
- **new_game synchronisation:** passes through a 2-flop synchroniser, then a rising-edge detector.
- **FSM states:** HOLD, PLAY, OVER.
- **PLAY:**
  - goal_p1 edge alone: score_p1 += 1, serve_dir ← 1 (serve to the player who conceded).
  - goal_p2 edge alone: score_p2 += 1, serve_dir ← 0.
  - If the new score equals WIN_SCORE: go to OVER; winner ← scorer.
  - Otherwise: go to HOLD with the counter loaded to HOLD_CYCLES-1.
  - Both goal edges in the same cycle: no score change, serve_dir unchanged, go to HOLD (re-serve).
- **HOLD:**
  - freeze = 1; goal edges are ignored and discarded (no latent count).
  - Counter decrements each cycle. At counter = 0: assert serve for one cycle, clear freeze, go to PLAY.
- **OVER:**
  - freeze = 1, game_over = 1; scores and winner held; goal edges ignored.
- **new_game edge (any state):**
  - Both scores ← 0, game_over ← 0, go to HOLD with the counter reloaded; serve_dir unchanged.
  - Takes priority over a goal edge in the same cycle.
- Scores never exceed WIN_SCORE; no wrap logic is needed because OVER blocks further counting.

## Timing
- **Reset values:**
  - score_p1 = score_p2 = 0, game_over = 0, winner = 0, freeze = 1, serve = 0, serve_dir = 0.
  - State = HOLD with counter = HOLD_CYCLES-1, so the first serve follows reset release.
- **Goal latency:** for a goal level first sampled high at edge k (low at k-1), the score changes at edge k+1; game_over/freeze also update at edge k+1.
- **Serve timing:** HOLD entered at edge j → serve high in the cycle after edge j+HOLD_CYCLES, for exactly one cycle. freeze falls at that same edge.
- **new_game latency** (no debounce): a button high setup-met before edge m → scores cleared after edge m+3 (2 sync + 1 edge-detect/update).
- **Reset mid-HOLD or mid-OVER:** immediate return to the reset values; no serve is emitted during reset.

## Configuration
- `SCORE_DEBOUNCE_EN` defined:
  - The synchronised new_game must hold a new level for 2^DEBOUNCE_BITS consecutive cycles before the debounced level changes; only a debounced 0→1 edge counts.
  - Latency grows by 2^DEBOUNCE_BITS cycles; glitches shorter than that are ignored.
- Undefined: the synchronised level drives the edge detector directly; DEBOUNCE_BITS is unused.

## Test plan
- **Reset release, HOLD_CYCLES=4:**
  - Scores 0, freeze=1 during reset.
  - serve pulses once 4 cycles after reset deassert; freeze=0 afterwards.
- **Single goal:** goal_p1 high for 10 cycles in PLAY → score_p1 0→1 exactly once, serve_dir=1, freeze=1 for 4 cycles, then one serve pulse.
- **Simultaneous goals:** goal_p1 and goal_p2 rise in the same cycle → scores unchanged, HOLD entered, serve after 4 cycles.
- **Game over:** 9 goal_p2 edges → score_p2=9, game_over=1, winner=1, freeze stays 1; a further goal_p1 edge leaves score_p1 unchanged.
- **Restart from OVER:** new_game pulse in OVER → scores 0, game_over=0 after 3 cycles; serve 4 cycles later.
- **Debounce** (`SCORE_DEBOUNCE_EN`, DEBOUNCE_BITS=3):
  - A 5-cycle glitch on new_game is ignored.
  - A 12-cycle press restarts the game once.
